// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment driver for DIGITS hex digits.
// New values are double-buffered and committed only when the scan wraps
// from the last digit back to digit 0, so a frame never mixes two values.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   enable         - 1 scans and drives segments; 0 blanks seg and freezes scan
//   in_valid       - one-cycle strobe capturing in_data/in_dp/in_lz as pending
//   in_data        - DIGITS hex nibbles, nibble k is digit k (digit 0 = LSD)
//   in_dp          - per-digit decimal point mask
//   in_lz          - leading-zero suppression enable
//   seg            - {a,b,c,d,e,f,g,dp}, active high, registered
//   which          - binary index of the digit being driven, registered
//   upd_pending    - a captured value waits for the next frame boundary
//   frame_tick     - one-cycle pulse in the cycle which first shows 0 after a wrap
module seg_scan_display #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 16384,
    parameter int WW       = $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [4*DIGITS-1:0] in_data,
    input  logic [DIGITS-1:0]   in_dp,
    input  logic                in_lz,
    output logic [7:0]          seg,
    output logic [WW-1:0]       which,
    output logic                upd_pending,
    output logic                frame_tick
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [4*DIGITS-1:0] pend_data, disp_data;
    logic [DIGITS-1:0]   pend_dp, disp_dp;
    logic                pend_lz, disp_lz;
    logic                pend_v;
    logic [PW-1:0]       presc;
    logic [WW-1:0]       idx;
    logic                wrap_r;

    logic                digit_end, frame_end;
    logic [3:0]          nib;
    logic                blank;
    logic                dp_bit;
    logic [7:0]          font;
    logic [7:0]          seg_next;

    assign digit_end = enable && (presc == PW'(SCAN_DIV - 1));
    assign frame_end = digit_end && (idx == WW'(DIGITS - 1));

    always_comb begin
        nib    = 4'(disp_data >> {idx, 2'b00});
        // Everything from this digit upward being zero means it is a leading zero.
        blank  = disp_lz && (idx != '0) && ((disp_data >> {idx, 2'b00}) == '0);
        dp_bit = disp_dp[idx];
        case (nib)
            4'h0:    font = 8'hFC;
            4'h1:    font = 8'h60;
            4'h2:    font = 8'hDA;
            4'h3:    font = 8'hF2;
            4'h4:    font = 8'h66;
            4'h5:    font = 8'hB6;
            4'h6:    font = 8'hBE;
            4'h7:    font = 8'hE0;
            4'h8:    font = 8'hFE;
            4'h9:    font = 8'hF6;
            4'hA:    font = 8'hEE;
            4'hB:    font = 8'h3E;
            4'hC:    font = 8'h9C;
            4'hD:    font = 8'h7A;
            4'hE:    font = 8'h9E;
            default: font = 8'h8E;
        endcase
        seg_next = enable ? {(blank ? 7'b0 : font[7:1]), dp_bit} : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_v     <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_lz    <= 1'b0;
            presc      <= '0;
            idx        <= '0;
            wrap_r     <= 1'b0;
            seg        <= 8'h00;
            which      <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (enable) begin
                if (digit_end) begin
                    presc <= '0;
                    idx   <= (idx == WW'(DIGITS - 1)) ? '0 : idx + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            // Commit reads the old pending copy; a same-cycle capture
            // replaces it afterwards and stays pending for the next frame.
            if (frame_end && pend_v) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                disp_lz   <= pend_lz;
            end
            if (in_valid) begin
                pend_data <= in_data;
                pend_dp   <= in_dp;
                pend_lz   <= in_lz;
                pend_v    <= 1'b1;
            end else if (frame_end) begin
                pend_v    <= 1'b0;
            end

            seg        <= seg_next;
            which      <= idx;
            // Delayed twice so the pulse lines up with which showing 0.
            wrap_r     <= frame_end;
            frame_tick <= wrap_r;
        end
    end

    assign upd_pending = pend_v;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;
    localparam int D = 8;
    localparam int S = 4;
    localparam int F = D * S;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           in_valid = 1'b0;
    logic [4*D-1:0] in_data = '0;
    logic [D-1:0]   in_dp = '0;
    logic           in_lz = 1'b0;
    logic [7:0]     seg;
    logic [2:0]     which;
    logic           upd_pending;
    logic           frame_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .in_dp(in_dp), .in_lz(in_lz),
        .seg(seg), .which(which), .upd_pending(upd_pending), .frame_tick(frame_tick)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [7:0] font_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                  8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    int         m_active;              // enabled cycles since reset
    logic [31:0] m_pd, m_dd;
    logic [7:0]  m_pdp, m_ddp;
    bit          m_plz, m_dlz, m_pv, m_wrap_last;
    logic [7:0]  exp_seg;
    int          exp_which;
    bit          exp_upd, exp_ft;

    function automatic logic [7:0] ref_digit(logic [31:0] data, logic [7:0] dp, bit lz, int k);
        logic [3:0] n;
        bit blank;
        n = data[4*k +: 4];
        blank = lz && (k > 0);
        for (int j = k; j < D; j++)
            if (data[4*j +: 4] != 4'h0) blank = 1'b0;
        return {(blank ? 7'b0 : font_tbl[n][7:1]), dp[k]};
    endfunction

    task automatic model_reset();
        m_active = 0; m_pd = '0; m_dd = '0; m_pdp = '0; m_ddp = '0;
        m_plz = 0; m_dlz = 0; m_pv = 0; m_wrap_last = 0;
        exp_seg = 8'h00; exp_which = 0; exp_upd = 0; exp_ft = 0;
    endtask

    task automatic model_edge();
        int  cur;
        bit  wrap;
        cur  = (m_active / S) % D;
        wrap = enable && ((m_active % F) == F - 1);
        exp_which = cur;
        exp_seg   = enable ? ref_digit(m_dd, m_ddp, m_dlz, cur) : 8'h00;
        exp_ft    = m_wrap_last;
        if (wrap && m_pv) begin
            m_dd = m_pd; m_ddp = m_pdp; m_dlz = m_plz; m_pv = 0;
        end
        if (in_valid) begin
            m_pd = in_data; m_pdp = in_dp; m_plz = in_lz; m_pv = 1;
        end
        if (enable) m_active++;
        m_wrap_last = wrap;
        exp_upd = m_pv;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("seg", seg, exp_seg);
        check("which", which, exp_which);
        check("upd_pending", upd_pending, exp_upd);
        check("frame_tick", frame_tick, exp_ft);
    endtask

    task automatic strobe(logic [31:0] d, logic [7:0] dp, bit lz);
        in_data = d; in_dp = dp; in_lz = lz; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic align(int t);
        for (int n = 0; n < F && (m_active % F) != t; n++) step();
    endtask

    task automatic wait_commit();
        for (int n = 0; n < 2 * F && upd_pending; n++) step();
        check("commit_wait", upd_pending, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        lz;
        logic [63:0] expd;   // digit k expected seg at [8k+:8]
    } vec_t;
    vec_t vecs [5];
    logic [7:0] got [8];
    bit   seen11;
    logic [7:0] d0_last;
    int   ticks;

    initial begin
        vecs[0] = '{32'h0000_1A3F, 8'h00, 1'b0, 64'hFCFCFCFC_60EEF28E};
        vecs[1] = '{32'h0000_1A3F, 8'h10, 1'b1, 64'h00000001_60EEF28E};
        vecs[2] = '{32'h0000_0000, 8'h00, 1'b1, 64'h00000000_000000FC};
        vecs[3] = '{32'h89AB_CDEF, 8'hFF, 1'b0, 64'hFFF7EF3F_9D7B9F8F};
        vecs[4] = '{32'h0100_0000, 8'h01, 1'b1, 64'h0060FCFC_FCFCFCFD};

        // reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", seg, 8'h00);
        check("reset_which", which, 0);
        check("reset_upd", upd_pending, 0);
        check("reset_tick", frame_tick, 0);
        rst_n = 1'b1; enable = 1'b1;

        // default display: all digits "0", ticks every frame
        for (int n = 0; n < 2 * F; n++) begin
            step();
            check("default_seg", seg, 8'hFC);
        end

        // table-driven vectors
        for (int v = 0; v < 5; v++) begin
            align(10);
            strobe(vecs[v].data, vecs[v].dp, vecs[v].lz);
            check("pending_after_strobe", upd_pending, 1);
            wait_commit();
            for (int k = 0; k < D; k++) got[k] = 8'hXX;
            for (int n = 0; n < F; n++) begin
                step();
                got[which] = seg;
            end
            for (int k = 0; k < D; k++)
                check($sformatf("vec%0d_digit%0d", v, k), got[k], vecs[v].expd[8*k +: 8]);
        end

        // overwrite within one frame: only 0x22 shows
        align(2);
        strobe(32'h11, 8'h00, 1'b0);
        repeat (3) step();
        strobe(32'h22, 8'h00, 1'b0);
        seen11 = 0; d0_last = 8'h00;
        for (int n = 0; n < 2 * F; n++) begin
            step();
            if (which == 0) begin
                if (seg == 8'h60) seen11 = 1;
                d0_last = seg;
            end
        end
        check("overwrite_never_11", seen11, 0);
        check("overwrite_shows_22", d0_last, 8'hDA);

        // capture in the exact wrap cycle
        align(5);
        strobe(32'h00, 8'h00, 1'b0);
        align(F - 1);
        strobe(32'h22, 8'h00, 1'b0);
        align(F - 1);
        strobe(32'h33, 8'h00, 1'b0);
        step();
        check("collide_commit_22", seg, 8'hDA);
        check("collide_33_pending", upd_pending, 1);
        repeat (F) step();
        check("collide_commit_33", seg, 8'hF2);
        check("collide_which", which, 0);
        check("collide_cleared", upd_pending, 0);

        // enable freeze mid-digit
        align(9);
        enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            check("freeze_seg", seg, 8'h00);
            check("freeze_which", which, 2);
        end
        enable = 1'b1;
        ticks = 0;
        for (int n = 0; n < 3 * F; n++) begin
            step();
            if (frame_tick) ticks++;
        end
        check("freeze_tick_count", ticks, 3);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            enable   = ($urandom_range(0, 7) != 0);
            in_valid = ($urandom_range(0, 15) == 0);
            in_data  = $urandom;
            if ($urandom_range(0, 1) == 1) in_data = in_data >> (4 * $urandom_range(1, 7));
            in_dp    = 8'($urandom);
            in_lz    = 1'($urandom);
            step();
        end
        enable = 1'b1; in_valid = 1'b0;

        // asynchronous reset with a pending update
        align(13);
        strobe(32'h8765_4321, 8'hAA, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_seg", seg, 8'h00);
        check("async_which", which, 0);
        check("async_upd", upd_pending, 0);
        check("async_tick", frame_tick, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 2 * F; n++) begin
            step();
            check("post_reset_zero", seg, 8'hFC);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
